// File: rtl/enemy_fire_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enemy_fire_ctrl_pkg
// Brief    : Shared game-control types and default constants for the enemy
//            fire scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package enemy_fire_ctrl_pkg;

  // Scheduler states: counting down, armed, strobing a slot, player dead.
  typedef enum logic [1:0] {
    COOL  = 2'd0,
    READY = 2'd1,
    FIRE  = 2'd2,
    OVER  = 2'd3
  } fire_state_t;

  localparam int ENEMY_SLOTS    = 4;
  localparam int ENEMY_COOLDOWN = 30;
  localparam int PLAYER_LIVES   = 3;

endpackage
`default_nettype wire

// File: rtl/enemy_fire_ctrl_rr_free_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_free_pick
// Brief    : Combinational round-robin search for the first free bullet slot,
//            starting at ptr and wrapping at N_SLOTS.
// Revision : 1.0 - initial release
// ============================================================================
module rr_free_pick #(
  parameter int N_SLOTS = 4,
  parameter int PTR_W   = 2
) (
  input  logic [N_SLOTS-1:0] busy,
  input  logic [PTR_W-1:0]   ptr,
  output logic               found,
  output logic [PTR_W-1:0]   idx
);

  // Walk offsets from farthest to nearest so the nearest free slot wins.
  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N_SLOTS) c = c - N_SLOTS;
      if (!busy[c[PTR_W-1:0]]) begin
        found = 1'b1;
        idx   = c[PTR_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/enemy_fire_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enemy_fire_ctrl
// Brief    : Enemy shot scheduler. Applies a frame-based cooldown, picks a free
//            bullet slot round-robin, strobes it for one cycle, and tracks the
//            player's lives from slot hit pulses.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_fire_ctrl
  import enemy_fire_ctrl_pkg::*;
#(
  parameter int N_SLOTS  = ENEMY_SLOTS,
  parameter int COOLDOWN = ENEMY_COOLDOWN,
  parameter int LIVES    = PLAYER_LIVES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               restart,
  input  logic               attack_req,
  input  logic               defend,
  input  logic [N_SLOTS-1:0] slot_busy,
  input  logic [N_SLOTS-1:0] slot_hit,
  output logic [N_SLOTS-1:0] fire,
  output logic               ready,
  output logic [3:0]         lives,
  output logic               game_over,
  output logic [7:0]         shots
);

  localparam int PTR_W = $clog2(N_SLOTS);
  localparam logic [7:0] C_COOLDOWN = 8'(COOLDOWN);
  localparam logic [3:0] C_LIVES    = 4'(LIVES);

  fire_state_t        r_state, w_state_nxt;
  logic [7:0]         r_cd, w_cd_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]   r_chosen, w_chosen_nxt;
  logic [3:0]         r_lives, w_lives_nxt, w_lives_left;
  logic [7:0]         r_shots, w_shots_nxt;
  logic [N_SLOTS-1:0] r_fire, w_fire_nxt;
  logic               r_ready, r_game_over;
  logic [3:0]         w_hit_cnt;
  logic               w_found;
  logic [PTR_W-1:0]   w_pick;
  logic               w_qualify;

  rr_free_pick #(
    .N_SLOTS (N_SLOTS),
    .PTR_W   (PTR_W)
  ) u_pick (
    .busy  (slot_busy),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pick)
  );

  // Number of hits landing this cycle.
  always_comb begin
    w_hit_cnt = 4'd0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_hit_cnt = w_hit_cnt + 4'(slot_hit[i]);
    end
  end

  assign w_qualify = frame_tick & attack_req & ~defend & w_found;

  // Next-state, counters and the strobe pattern for the following cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cd_nxt     = r_cd;
    w_ptr_nxt    = r_ptr;
    w_chosen_nxt = r_chosen;
    w_lives_nxt  = r_lives;
    w_shots_nxt  = r_shots;
    w_fire_nxt   = '0;
    w_lives_left = (r_lives > w_hit_cnt) ? (r_lives - w_hit_cnt) : 4'd0;

    if (restart) begin
      w_state_nxt  = READY;
      w_cd_nxt     = 8'd0;
      w_ptr_nxt    = '0;
      w_chosen_nxt = '0;
      w_lives_nxt  = C_LIVES;
      w_shots_nxt  = 8'd0;
    end else begin
      case (r_state)
        COOL: begin
          if (frame_tick) begin
            if (r_cd <= 8'd1) begin
              w_cd_nxt    = 8'd0;
              w_state_nxt = READY;
            end else begin
              w_cd_nxt = r_cd - 8'd1;
            end
          end
        end
        READY: begin
          if (w_qualify) begin
            w_state_nxt  = FIRE;
            w_chosen_nxt = w_pick;
            w_ptr_nxt    = (w_pick == PTR_W'(N_SLOTS - 1)) ? '0 : (w_pick + PTR_W'(1));
          end
        end
        FIRE: begin
          // A frame_tick here is deliberately not counted toward cooldown.
          w_cd_nxt    = C_COOLDOWN;
          w_shots_nxt = (r_shots == 8'hFF) ? r_shots : (r_shots + 8'd1);
          w_state_nxt = COOL;
        end
        OVER: begin
          w_state_nxt = OVER;
        end
        default: begin
          w_state_nxt = READY;
        end
      endcase

      // A killing hit overrides any pending shot; the slot pointer is kept.
      if (r_state != OVER) begin
        w_lives_nxt = w_lives_left;
        if (w_lives_left == 4'd0) begin
          w_state_nxt  = OVER;
          w_ptr_nxt    = r_ptr;
          w_chosen_nxt = r_chosen;
        end
      end
    end

    if (w_state_nxt == FIRE) w_fire_nxt[w_chosen_nxt] = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= READY;
      r_cd        <= 8'd0;
      r_ptr       <= '0;
      r_chosen    <= '0;
      r_lives     <= C_LIVES;
      r_shots     <= 8'd0;
      r_fire      <= '0;
      r_ready     <= 1'b1;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cd        <= w_cd_nxt;
      r_ptr       <= w_ptr_nxt;
      r_chosen    <= w_chosen_nxt;
      r_lives     <= w_lives_nxt;
      r_shots     <= w_shots_nxt;
      r_fire      <= w_fire_nxt;
      r_ready     <= (w_state_nxt == READY);
      r_game_over <= (w_state_nxt == OVER);
    end
  end

  assign fire      = r_fire;
  assign ready     = r_ready;
  assign lives     = r_lives;
  assign game_over = r_game_over;
  assign shots     = r_shots;

endmodule
`default_nettype wire
